// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice reused over WIDTH/CHUNK cycles,
// LSB chunk first, with valid/ready handshakes on both sides.
module serial_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk;
   logic               c_chunk;
   logic               last_chunk;

   // Shared ripple slice; b_q already holds ~b for subtraction.
   always_comb begin
      a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
      b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
      {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
   end

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if (last_chunk) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
            end
         end
         BUSY: begin
            sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_chunk;
            carry_d = c_chunk;
            if (last_chunk) begin
               idx_d  = '0;
               cout_d = c_chunk;
               // Carry into the MSB is recovered from the MSB's own sum bit.
               ovf_d  = c_chunk ^ (a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1]);
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Multi-cycle parametrised adder/subtractor built around a CHUNK-bit ripple slice, reused over WIDTH/CHUNK clock cycles (LSB chunk first).
- Successor to the combinational fixed-width adder tests: generic width, carry-in, subtract mode and signed-overflow flag.
- Valid/ready handshakes on both sides, so it drops into simulator test pipelines as a timed sequential stage.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle; NCHUNK = WIDTH/CHUNK, minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 selects A-B, 0 selects A+B+cin.
- out_valid  output  1  result available, high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of MSB; for subtract, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, active-high): state=IDLE, sum=0, cout=0, overflow=0, out_valid=0, chunk index=0. in_ready=1 once rst deasserts.
- Reset mid-operation aborts the transaction; no out_valid for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a; latch b (bitwise inverted when sub=1); set carry = sub ? 1 : cin; set index=0; go to BUSY.
  - in_valid=0: stay in IDLE.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge: sum[index*CHUNK +: CHUNK] = a_chunk + b_chunk + carry; carry updates; index increments.
  - On the last chunk: record carry-in to bit WIDTH-1 for overflow, set cout to the final carry, go to DONE.
  - BUSY lasts exactly NCHUNK cycles.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - out_valid=1 with out_ready=1 on an edge: go to IDLE. out_valid drops next cycle and in_ready rises.
  - out_ready=0: stay in DONE indefinitely; inputs are ignored.
- Latency and throughput:
  - out_valid rises NCHUNK cycles after the accept edge.
  - in_ready is back NCHUNK+1 cycles after accept if out_ready is held high, so the minimum period is NCHUNK+1 cycles per operation.
- Stability:
  - Input ports are sampled only on the accept edge; later changes have no effect.
  - sum bits not yet computed in BUSY are don't-care.
  - Outputs are registered; only in_ready and out_valid decode directly from state.
- Width rules:
  - Results are modulo 2^WIDTH.
  - For sub, cin is ignored and the operation is a + ~b + 1.
  - With CHUNK=WIDTH the block is a single-cycle registered adder (BUSY lasts 1 cycle).

Test Plan:
- WIDTH=8, CHUNK=2; a=0x5A, b=0x33, cin=0, sub=0 -> sum=0x8D, cout=0, overflow=1; out_valid exactly 4 cycles after accept.
- a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, overflow=0. Repeat with cin=1 -> sum=0x01, cout=1.
- sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0, overflow=0. sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1. cin toggled has no effect.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b. Required: out_valid stays 1, sum/cout/overflow unchanged, in_ready=0, no new operand accepted. Releasing out_ready gives IDLE on the next cycle.
- Assert rst 2 cycles into BUSY. Required: immediate sum=0, out_valid=0, state IDLE. The next transaction a=0x01, b=0x02 gives sum=0x03 with normal latency.
- WIDTH=8, CHUNK=8; a=0x7F, b=0x01, cin=1 -> sum=0x81, cout=0, overflow=1; out_valid 1 cycle after accept.
